hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter NUM_SRC, default 2, source operands per instruction (range 1..3).
REQ-003 Parameter MUL_LAT, default 4, multicycle-unit latency in cycles (range 2..15).
REQ-004 Port clk  in  1  sole clock; all state on rising edge.
REQ-005 Port arst_n  in  1  asynchronous active-low reset.
REQ-006 Port id_src  in  NUM_SRC*ADDR_W  ID-stage source register addresses; operand k is slice k.
REQ-007 Port id_src_used  in  NUM_SRC  per-operand read-valid for the ID instruction.
REQ-008 Port id_rd  in  ADDR_W  ID-stage destination.
REQ-009 Port id_reg_write  in  1  ID instruction writes id_rd.
REQ-010 Port id_mul  in  1  ID instruction is a multicycle operation.
REQ-011 Port ex_src  in  NUM_SRC*ADDR_W  EX-stage source addresses, used for forwarding.
REQ-012 Port ex_rd, ex_reg_write, ex_mem_read  in  ADDR_W/1/1  EX destination, write flag, and load flag.
REQ-013 Port mem_rd, mem_reg_write  in  ADDR_W/1  MEM-stage destination and write flag.
REQ-014 Port wb_rd, wb_reg_write  in  ADDR_W/1  WB-stage destination and write flag.
REQ-015 Port flush  in  1  taken branch/jump: kills the ID instruction this cycle.
REQ-016 Port forward_sel  out  2*NUM_SRC  per-operand select: 00 regfile, 10 WB, 11 MEM.
REQ-017 Port stall  out  1  hold PC and IF/ID this cycle.
REQ-018 Port bubble  out  1  load NOP into ID/EX this cycle.
REQ-019 Port mul_busy  out  1  multicycle unit occupied.
REQ-020 Port mul_done  out  1  one-cycle pulse when the multicycle result is written back.

Function
REQ-021 forward_sel[k] SHALL be combinational: 11 if ex_src[k]==mem_rd, mem_rd!=0, and mem_reg_write; otherwise 10 if the same conditions hold for WB; otherwise 00 (MEM has priority).
REQ-022 Register address 0 SHALL never cause forwarding or stalls.
REQ-023 load_use SHALL assert when ex_mem_read, ex_reg_write, ex_rd!=0, and some used id_src[k]==ex_rd.
REQ-024 sb_hit SHALL assert when state is BUSY and either some used id_src[k]==mul_rd (mul_rd!=0), or id_mul is set, or id_reg_write is set with id_rd==mul_rd.
REQ-025 stall and bubble SHALL equal (load_use | sb_hit) & ~flush; flush overrides, and the killed instruction raises no hazard.
REQ-026 The FSM SHALL have states IDLE and BUSY, and reset into IDLE.
REQ-027 IDLE->BUSY SHALL occur when id_mul & ~stall & ~flush; it loads cnt=MUL_LAT-1 and mul_rd=id_rd (mul_rd=0 if ~id_reg_write).
REQ-028 In BUSY, cnt SHALL decrement each cycle; at cnt==0 mul_done pulses and the state returns to IDLE the next cycle.
REQ-029 A new issue SHALL not occur in the cycle mul_done pulses, because sb_hit blocks id_mul while BUSY; the earliest re-issue is the following cycle.
REQ-030 mul_busy SHALL be high exactly in BUSY; cnt width is $clog2(MUL_LAT).
REQ-031 flush SHALL NOT affect an operation already in BUSY.

Reset
REQ-032 On arst_n low, the block SHALL immediately enter IDLE with cnt=0, mul_rd=0, mul_done=0, and mul_busy=0.
REQ-033 A mid-operation reset SHALL abandon the in-flight operation without a mul_done pulse.
REQ-034 Combinational outputs SHALL follow their inputs during reset, but sb_hit is 0.
REQ-035 Reset release SHALL be synchronous to clk through the system reset synchroniser.

Structure
REQ-036 Forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and FSM state encodings SHALL reside in the shared pipeline package.
REQ-037 One sub-module, hazard_fwd_mux_sel, SHALL compute the select for a single operand and be instantiated NUM_SRC times by generate.

Verification
REQ-038 ex_src0=3, mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1 -> forward_sel[1:0]=11; with mem_reg_write=0 -> 10.
REQ-039 ex_mem_read=1, ex_rd=5, id_src1=5 used -> stall=bubble=1 for exactly one cycle; with id_src_used[1]=0 -> 0.
REQ-040 Issue mul rd=7 with MUL_LAT=4 -> mul_busy for 4 cycles, mul_done on the 4th; a dependent id_src0=7 stalls until the cycle after mul_done.
REQ-041 Load-use hazard with flush=1 in the same cycle -> stall=0, bubble=0, and no issue.
REQ-042 arst_n low at cnt=2 -> immediately mul_busy=0 and no mul_done; a new mul issues normally after release.
REQ-043 Any hazard condition with a register address of 0 -> forward_sel=00 and stall=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings for the hazard unit:
// forwarding selects and multicycle FSM states.
package hazard_unit_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [1:0] FWD_MEM = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mul_state_t;

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Forward select for one EX operand.
// MEM result is younger than WB, so it wins.
module hazard_fwd_mux_sel
   import hazard_unit_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              wb_reg_write,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_reg_write && (mem_rd != '0)
                    && (src == mem_rd);
   assign wb_hit  = wb_reg_write && (wb_rd != '0)
                    && (src == wb_rd);

   // pick the youngest producer of this operand
   always_comb begin
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use
// stalls and a scoreboard for one multicycle unit.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int MUL_LAT = 4
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [NUM_SRC*ADDR_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic [ADDR_W-1:0]         id_rd,
   input  logic                      id_reg_write,
   input  logic                      id_mul,
   input  logic [NUM_SRC*ADDR_W-1:0] ex_src,
   input  logic [ADDR_W-1:0]         ex_rd,
   input  logic                      ex_reg_write,
   input  logic                      ex_mem_read,
   input  logic [ADDR_W-1:0]         mem_rd,
   input  logic                      mem_reg_write,
   input  logic [ADDR_W-1:0]         wb_rd,
   input  logic                      wb_reg_write,
   input  logic                      flush,
   output logic [2*NUM_SRC-1:0]      forward_sel,
   output logic                      stall,
   output logic                      bubble,
   output logic                      mul_busy,
   output logic                      mul_done
);

   localparam int CNT_W = $clog2(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'(MUL_LAT - 1);

   mul_state_t        state;
   mul_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [ADDR_W-1:0] mul_rd;
   logic [ADDR_W-1:0] mul_rd_nxt;

   logic load_use;
   logic sb_hit;
   logic raw_mul;
   logic hazard;
   logic issue;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
      hazard_fwd_mux_sel #(
         .ADDR_W (ADDR_W)
      ) u_sel (
         .src           (ex_src[k*ADDR_W +: ADDR_W]),
         .mem_rd        (mem_rd),
         .mem_reg_write (mem_reg_write),
         .wb_rd         (wb_rd),
         .wb_reg_write  (wb_reg_write),
         .sel           (forward_sel[2*k +: 2])
      );
   end

   // a used ID operand waits on a load still in EX
   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && ex_reg_write
          && (ex_rd != '0)) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k]
                && (id_src[k*ADDR_W +: ADDR_W] == ex_rd))
               load_use = 1'b1;
         end
      end
   end

   // a used ID operand reads the pending mul result
   always_comb begin
      raw_mul = 1'b0;
      if (mul_rd != '0) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k]
                && (id_src[k*ADDR_W +: ADDR_W] == mul_rd))
               raw_mul = 1'b1;
         end
      end
   end

   // busy unit blocks RAW, a second mul and WAW on mul_rd
   always_comb begin
      sb_hit = 1'b0;
      if (state == BUSY) begin
         sb_hit = raw_mul || id_mul
                  || (id_reg_write && (mul_rd != '0)
                      && (id_rd == mul_rd));
      end
   end

   assign hazard = load_use || sb_hit;
   assign stall  = hazard && !flush;
   assign bubble = hazard && !flush;
   assign issue  = id_mul && !stall && !flush;

   // scoreboard state, counter and tracked destination
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         mul_rd <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         mul_rd <= mul_rd_nxt;
      end
   end

   // next-state: issue from IDLE, count down in BUSY
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mul_rd_nxt = mul_rd;
      mul_busy   = 1'b0;
      mul_done   = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nxt  = BUSY;
               cnt_nxt    = CNT_INIT;
               mul_rd_nxt = id_reg_write ? id_rd : '0;
            end
         end
         BUSY: begin
            mul_busy = 1'b1;
            if (cnt == '0) begin
               mul_done  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with default
// parameters (ADDR_W=5, NUM_SRC=2, MUL_LAT=4).
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mul;
   logic [9:0]  ex_src;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        flush;
   logic [3:0]  forward_sel;
   logic        stall;
   logic        bubble;
   logic        mul_busy;
   logic        mul_done;

   int total = 0;
   int bad   = 0;

   hazard_unit dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .id_src        (id_src),
      .id_src_used   (id_src_used),
      .id_rd         (id_rd),
      .id_reg_write  (id_reg_write),
      .id_mul        (id_mul),
      .ex_src        (ex_src),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .flush         (flush),
      .forward_sel   (forward_sel),
      .stall         (stall),
      .bubble        (bubble),
      .mul_busy      (mul_busy),
      .mul_done      (mul_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_src        = '0;
      id_src_used   = '0;
      id_rd         = '0;
      id_reg_write  = 1'b0;
      id_mul        = 1'b0;
      ex_src        = '0;
      ex_rd         = '0;
      ex_reg_write  = 1'b0;
      ex_mem_read   = 1'b0;
      mem_rd        = '0;
      mem_reg_write = 1'b0;
      wb_rd         = '0;
      wb_reg_write  = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      clear_inputs();
      step();
      step();
      total++;
      if (mul_busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy got=%b want=0", mul_busy);
      end
      total++;
      if (mul_done !== 1'b0) begin
         bad++;
         $display("FAIL rst_done got=%b want=0", mul_done);
      end
      total++;
      if ({stall, bubble, forward_sel} !== 6'b0) begin
         bad++;
         $display("FAIL rst_outs got=%b want=0",
                  {stall, bubble, forward_sel});
      end
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_forward();
      clear_inputs();
      ex_src[4:0]   = 5'd3;
      mem_rd        = 5'd3;
      mem_reg_write = 1'b1;
      wb_rd         = 5'd3;
      wb_reg_write  = 1'b1;
      #1;
      total++;
      if (forward_sel[1:0] !== 2'b11) begin
         bad++;
         $display("FAIL fwd_mem got=%b want=11",
                  forward_sel[1:0]);
      end
      mem_reg_write = 1'b0;
      #1;
      total++;
      if (forward_sel[1:0] !== 2'b10) begin
         bad++;
         $display("FAIL fwd_wb got=%b want=10",
                  forward_sel[1:0]);
      end
      wb_reg_write  = 1'b0;
      ex_src[9:5]   = 5'd9;
      mem_rd        = 5'd9;
      mem_reg_write = 1'b1;
      #1;
      total++;
      if (forward_sel !== 4'b1100) begin
         bad++;
         $display("FAIL fwd_op1 got=%b want=1100",
                  forward_sel);
      end
      step();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_mem_read    = 1'b1;
      ex_reg_write   = 1'b1;
      ex_rd          = 5'd5;
      id_src[9:5]    = 5'd5;
      id_src_used    = 2'b10;
      #1;
      total++;
      if ({stall, bubble} !== 2'b11) begin
         bad++;
         $display("FAIL lu_hit got=%b want=11",
                  {stall, bubble});
      end
      step();
      ex_mem_read  = 1'b0;
      ex_reg_write = 1'b0;
      ex_rd        = 5'd0;
      #1;
      total++;
      if ({stall, bubble} !== 2'b00) begin
         bad++;
         $display("FAIL lu_after got=%b want=00",
                  {stall, bubble});
      end
      ex_mem_read  = 1'b1;
      ex_reg_write = 1'b1;
      ex_rd        = 5'd5;
      id_src_used  = 2'b01;
      #1;
      total++;
      if ({stall, bubble} !== 2'b00) begin
         bad++;
         $display("FAIL lu_unused got=%b want=00",
                  {stall, bubble});
      end
      step();
   endtask

   task automatic test_zero();
      clear_inputs();
      ex_src        = '0;
      mem_rd        = '0;
      mem_reg_write = 1'b1;
      wb_rd         = '0;
      wb_reg_write  = 1'b1;
      ex_mem_read   = 1'b1;
      ex_reg_write  = 1'b1;
      ex_rd         = '0;
      id_src        = '0;
      id_src_used   = 2'b11;
      #1;
      total++;
      if ({forward_sel, stall} !== 5'b0) begin
         bad++;
         $display("FAIL zero_haz got=%b want=00000",
                  {forward_sel, stall});
      end
      clear_inputs();
      id_mul = 1'b1;
      step();
      id_mul       = 1'b0;
      id_src_used  = 2'b11;
      id_reg_write = 1'b1;
      #1;
      total++;
      if ({mul_busy, stall} !== 2'b10) begin
         bad++;
         $display("FAIL zero_sb got=%b want=10",
                  {mul_busy, stall});
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_mul();
      clear_inputs();
      id_mul       = 1'b1;
      id_reg_write = 1'b1;
      id_rd        = 5'd7;
      #1;
      total++;
      if ({stall, mul_busy} !== 2'b00) begin
         bad++;
         $display("FAIL mul_issue got=%b want=00",
                  {stall, mul_busy});
      end
      step();
      id_mul      = 1'b0;
      id_rd       = 5'd8;
      id_src[4:0] = 5'd7;
      id_src_used = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({mul_busy, mul_done, stall} !==
             {2'b1, (i == 3), 1'b1}) begin
            bad++;
            $display("FAIL mul_cyc%0d got=%b want=%b", i,
                     {mul_busy, mul_done, stall},
                     {2'b1, (i == 3), 1'b1});
         end
         step();
      end
      #1;
      total++;
      if ({mul_busy, mul_done, stall} !== 3'b000) begin
         bad++;
         $display("FAIL mul_end got=%b want=000",
                  {mul_busy, mul_done, stall});
      end
      step();
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      id_mul       = 1'b1;
      id_reg_write = 1'b1;
      id_rd        = 5'd7;
      step();
      id_rd = 5'd9;
      for (int i = 0; i < 4; i++) begin
         flush = (i == 1);
         #1;
         total++;
         if ({mul_busy, mul_done, stall} !==
             {1'b1, (i == 3), (i != 1)}) begin
            bad++;
            $display("FAIL b2b_cyc%0d got=%b want=%b", i,
                     {mul_busy, mul_done, stall},
                     {1'b1, (i == 3), (i != 1)});
         end
         step();
      end
      flush = 1'b0;
      #1;
      total++;
      if ({mul_busy, stall} !== 2'b00) begin
         bad++;
         $display("FAIL b2b_gap got=%b want=00",
                  {mul_busy, stall});
      end
      step();
      clear_inputs();
      id_reg_write = 1'b1;
      id_rd        = 5'd9;
      #1;
      total++;
      if ({mul_busy, stall} !== 2'b11) begin
         bad++;
         $display("FAIL b2b_waw got=%b want=11",
                  {mul_busy, stall});
      end
      id_rd = 5'd10;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL b2b_indep got=%b want=0", stall);
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_flush();
      clear_inputs();
      ex_mem_read  = 1'b1;
      ex_reg_write = 1'b1;
      ex_rd        = 5'd6;
      id_src[4:0]  = 5'd6;
      id_src_used  = 2'b01;
      id_mul       = 1'b1;
      id_reg_write = 1'b1;
      id_rd        = 5'd12;
      flush        = 1'b1;
      #1;
      total++;
      if ({stall, bubble} !== 2'b00) begin
         bad++;
         $display("FAIL fl_stall got=%b want=00",
                  {stall, bubble});
      end
      step();
      clear_inputs();
      #1;
      total++;
      if (mul_busy !== 1'b0) begin
         bad++;
         $display("FAIL fl_noissue got=%b want=0",
                  mul_busy);
      end
      step();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      id_mul = 1'b1;
      step();
      id_mul = 1'b0;
      step();
      arst_n        = 1'b0;
      ex_src[4:0]   = 5'd4;
      mem_rd        = 5'd4;
      mem_reg_write = 1'b1;
      #1;
      total++;
      if ({mul_busy, mul_done} !== 2'b00) begin
         bad++;
         $display("FAIL mid_rst got=%b want=00",
                  {mul_busy, mul_done});
      end
      total++;
      if (forward_sel[1:0] !== 2'b11) begin
         bad++;
         $display("FAIL mid_fwd got=%b want=11",
                  forward_sel[1:0]);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (mul_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_nodone got=%b want=0",
                     mul_done);
         end
      end
      arst_n = 1'b1;
      clear_inputs();
      step();
      id_mul       = 1'b1;
      id_reg_write = 1'b1;
      id_rd        = 5'd4;
      step();
      id_mul = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({mul_busy, mul_done} !==
             {1'b1, (i == 3)}) begin
            bad++;
            $display("FAIL mid_re%0d got=%b want=%b", i,
                     {mul_busy, mul_done},
                     {1'b1, (i == 3)});
         end
         step();
      end
      #1;
      total++;
      if (mul_busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_end got=%b want=0", mul_busy);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_zero();
      test_mul();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
